mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Data-side memory controller sitting directly downstream of cpu_core's MEM stage.
- Consumes mem_addr / mem_wdata / mem_ctrl_signal and returns mem_rdata / mem_stall.
- Converts each request into a timed access on one 32-bit asynchronous SRAM bank (1M words).
- Handles byte/half/word lane selection and load sign/zero extension.

Parameters:
- READ_WAIT, 2, cycles SRAM output enable is held before read data is sampled (>=1)
- WRITE_WAIT, 2, cycles the we_n pulse is held low (>=1)
- SRAM_AW, 20, SRAM word-address width

Ports:
- clk_50M  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  byte address from MEM stage; bits [SRAM_AW+1:2] select the word
- mem_wdata  in  32  store data, right-aligned
- mem_ctrl_signal  in  5  [0] read, [1] write, [2] signed load, [4:3] size (00 byte, 01 half, 10 word, 11 treated as word)
- mem_rdata  out  32  load result, extended, right-aligned
- mem_stall  out  1  high while a request is not yet complete
- sram_addr  out  SRAM_AW  word address
- sram_dq_o  out  32  write data to pads
- sram_dq_i  in  32  read data from pads
- sram_dq_oe  out  1  pad output enable, 1 = drive
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  4  active-low byte enables

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ce_n/oe_n/we_n = 1, be_n = 4'hF, dq_oe = 0, sram_addr = 0, sram_dq_o = 0, mem_rdata = 0.
  - mem_stall = 0 while rst_n is low.
  - Reset mid-access aborts the access immediately; we_n returns high in the same instant.
- Request:
  - A request exists when read or write is set. If both are set, write wins.
  - No request: IDLE, mem_stall = 0.
- mem_stall = request present AND state != DONE. It is combinational, so it rises in the same cycle the request appears.
- The CPU holds its inputs stable while stalled. The controller latches address, data, size and signed at the IDLE->access transition.
- Lanes:
  - Byte: be_n = ~(1 << addr[1:0]); write data replicated into all 4 bytes.
  - Half: be_n = addr[1] ? 4'b0011 : 4'b1100; data replicated into both halves.
  - Word: be_n = 4'h0.
  - Misaligned addr[0] for half, or addr[1:0] for word, is ignored (forced aligned). No exception is raised.
- Read FSM: IDLE -> RD (READ_WAIT cycles) -> DONE -> IDLE.
  - RD: ce_n = 0, oe_n = 0, dq_oe = 0, be_n = 0.
  - At the last RD edge, sram_dq_i is lane-selected, extended (sign if [2], else zero) and registered into mem_rdata.
  - mem_rdata holds until the next read completes.
- Write FSM: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WRITE_WAIT cycles) -> WR_HOLD (1 cycle) -> DONE -> IDLE.
  - WR_SETUP: ce_n = 0, dq_oe = 1, addr/be/data valid, we_n = 1.
  - WR_PULSE: we_n = 0.
  - WR_HOLD: we_n = 1, ce_n/dq_oe/addr/data unchanged.
  - oe_n = 1 throughout.
- DONE: strobes inactive, mem_stall = 0. The CPU advances on this edge.
- Latency (request at cycle 0, stall falls in cycle N):
  - Read: N = READ_WAIT + 1.
  - Write: N = WRITE_WAIT + 3.
- Back-to-back: a request seen in IDLE the cycle after DONE starts a new access. No request is lost and none is repeated.
- Request withdrawn mid-access (illegal): the access completes anyway, and the result is discarded by the CPU.

Test Plan:
- rst_n low during a WR_PULSE -> we_n = 1 asynchronously; after release, state is IDLE and mem_stall = 0 with no request.
- Word write addr 0x0000_0010, data 0xDEADBEEF, then word read of the same address:
  - Write: sram_addr = 4, be_n = 0, we_n low for exactly 2 cycles, stall high 5 cycles.
  - Read: stall high 3 cycles, mem_rdata = 0xDEADBEEF.
- SRAM word 0x80FF7F01:
  - Signed byte load addr[1:0]=3 -> 0xFFFFFF80.
  - Unsigned byte at addr[1:0]=2 -> 0x000000FF.
  - Signed half at addr[1]=0 -> 0x00007F01.
  - Signed half at addr[1]=1 -> 0xFFFF80FF.
- Byte store 0x000000AB at addr[1:0]=1 -> be_n = 4'b1101, sram_dq_o = 0xABABABAB. A following word read returns only byte 1 changed.
- Word read immediately followed by word write (no idle gap from CPU) -> two distinct accesses with stall patterns 3 then 5 cycles; the write's data lands at its own address.
- Misaligned word read at 0x0000_0013 -> sram_addr = 4, full word returned, no hang.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: data-side memory controller between the CPU MEM stage and a
// single 32-bit asynchronous SRAM bank. Each load/store becomes a timed SRAM
// access with lane selection on stores and sign/zero extension on loads.
// mem_stall holds the CPU until the access reaches DONE.

module mem_sram_ctrl #(
    parameter int READ_WAIT  = 2,   // cycles oe_n is held low before sampling (>=1)
    parameter int WRITE_WAIT = 2,   // cycles we_n is held low (>=1)
    parameter int SRAM_AW    = 20   // SRAM word-address width
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [4:0]         mem_ctrl_signal,
    output logic [31:0]        mem_rdata,
    output logic               mem_stall,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_dq_o,
    input  logic [31:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_size;
    logic [1:0]         r_lane;
    logic               r_signed;

    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_addr;
    logic [31:0]        r_dq_o;
    logic               r_dq_oe;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic [3:0]         r_be_n;

    logic               w_req;
    logic               w_is_write;
    logic [1:0]         w_size;
    logic [1:0]         w_lane;
    logic [3:0]         w_wr_be_n;
    logic [31:0]        w_wr_data;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [31:0]        w_rd_ext;
    logic               w_unused_addr;

    assign w_req      = mem_ctrl_signal[0] | mem_ctrl_signal[1];
    assign w_is_write = mem_ctrl_signal[1];          // write wins if both set
    assign w_size     = mem_ctrl_signal[4:3];
    assign w_lane     = mem_addr[1:0];

    // Address bits above the SRAM word range have no meaning for this bank.
    assign w_unused_addr = ^mem_addr[31:SRAM_AW+2];

    // Stall is combinational so it rises in the very cycle a request appears;
    // it is forced low while reset is asserted.
    assign mem_stall = rst_n & w_req & (r_state != S_DONE);

    // Store lane enables and replicated store data for the incoming request.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_wr_be_n = 4'h0;
        w_wr_data = mem_wdata;
        case (w_size)
            SZ_BYTE: begin
                w_wr_be_n = ~(4'b0001 << w_lane);
                w_wr_data = {4{mem_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_wr_be_n = w_lane[1] ? 4'b0011 : 4'b1100;
                w_wr_data = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_wr_be_n = 4'h0;
                w_wr_data = mem_wdata;
            end
        endcase
    end

    // Load lane selection and extension from the pad data, using latched size/lane.
    always_comb begin
        w_rd_byte = sram_dq_i[{r_lane, 3'b000} +: 8];
        w_rd_half = r_lane[1] ? sram_dq_i[31:16] : sram_dq_i[15:0];
        w_rd_ext  = sram_dq_i;
        case (r_size)
            SZ_BYTE: w_rd_ext = r_signed ? {{24{w_rd_byte[7]}}, w_rd_byte}
                                         : {24'h0, w_rd_byte};
            SZ_HALF: w_rd_ext = r_signed ? {{16{w_rd_half[15]}}, w_rd_half}
                                         : {16'h0, w_rd_half};
            default: w_rd_ext = sram_dq_i;
        endcase
    end

    // Access sequencer: state, wait counter, latched request and registered strobes.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_size   <= 2'b00;
            r_lane   <= 2'b00;
            r_signed <= 1'b0;
            r_rdata  <= 32'h0;
            r_addr   <= '0;
            r_dq_o   <= 32'h0;
            r_dq_oe  <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_be_n   <= 4'hF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr   <= mem_addr[SRAM_AW+1:2];
                        r_size   <= w_size;
                        r_lane   <= w_lane;
                        r_signed <= mem_ctrl_signal[2];
                        r_cnt    <= '0;
                        r_ce_n   <= 1'b0;
                        if (w_is_write) begin
                            r_dq_oe <= 1'b1;
                            r_be_n  <= w_wr_be_n;
                            r_dq_o  <= w_wr_data;
                            r_state <= S_WR_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_be_n  <= 4'h0;
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_rdata <= w_rd_ext;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_be_n  <= 4'hF;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_cnt == WR_LAST) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR_HOLD: begin
                    r_ce_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_be_n  <= 4'hF;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata  = r_rdata;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_be_n  = r_be_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed and randomized loads/stores against an SRAM model.
// A byte-level reference memory predicts every access; a monitor process pops
// expectations from a scoreboard queue whenever the DUT drops mem_stall.

module tb_mem_sram_ctrl;

    localparam int READ_WAIT  = 2;
    localparam int WRITE_WAIT = 2;
    localparam int SRAM_AW    = 20;

    localparam logic [4:0] R_WORD   = 5'b10001;
    localparam logic [4:0] W_WORD   = 5'b10010;
    localparam logic [4:0] R_BYTE_S = 5'b00101;
    localparam logic [4:0] R_BYTE_U = 5'b00001;
    localparam logic [4:0] R_HALF_S = 5'b01101;
    localparam logic [4:0] W_BYTE   = 5'b00010;

    logic               clk_50M;
    logic               rst_n;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [4:0]         mem_ctrl_signal;
    logic [31:0]        mem_rdata;
    logic               mem_stall;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_dq_o;
    logic [31:0]        sram_dq_i;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;
    logic [3:0]         sram_be_n;

    mem_sram_ctrl #(
        .READ_WAIT (READ_WAIT),
        .WRITE_WAIT(WRITE_WAIT),
        .SRAM_AW   (SRAM_AW)
    ) dut (
        .clk_50M        (clk_50M),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ctrl_signal(mem_ctrl_signal),
        .mem_rdata      (mem_rdata),
        .mem_stall      (mem_stall),
        .sram_addr      (sram_addr),
        .sram_dq_o      (sram_dq_o),
        .sram_dq_i      (sram_dq_i),
        .sram_dq_oe     (sram_dq_oe),
        .sram_ce_n      (sram_ce_n),
        .sram_oe_n      (sram_oe_n),
        .sram_we_n      (sram_we_n),
        .sram_be_n      (sram_be_n)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0111);
    endfunction

    // Asynchronous SRAM model (64 words are enough for the address range used).
    logic [31:0] sram [0:63];
    initial for (int i = 0; i < 64; i++) sram[i] <= init_word(i);

    always @(posedge clk_50M) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram[sram_addr[5:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    always @(negedge clk_50M) begin
        sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[5:0]] : 32'hBAD0_BAD0;
    end

    // Reference memory and scoreboard.
    logic [31:0] ref_mem [0:63];

    typedef struct {
        bit          is_write;
        logic [19:0] waddr;
        logic [3:0]  be_n;
        logic [31:0] dq;
        logic [31:0] rdata;
        int          stall;
        int          we_cycles;
        int          oe_cycles;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    function automatic int span_len(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Predict the access from byte-lane rules and update the reference memory.
    function automatic exp_t predict(input logic [4:0] ctrl, input logic [31:0] addr,
                                     input logic [31:0] wdata);
        exp_t        e;
        int          len   = span_len(ctrl[4:3]);
        int          start = (int'(addr[1:0]) / len) * len;
        int          idx   = int'(addr[7:2]);
        logic [31:0] v;
        logic [31:0] mask;
        e.waddr = addr[21:2];
        if (ctrl[1]) begin
            e.is_write  = 1'b1;
            e.stall     = WRITE_WAIT + 3;
            e.we_cycles = WRITE_WAIT;
            e.oe_cycles = 0;
            e.rdata     = 32'h0;
            for (int k = 0; k < 4; k++) begin
                bit in_span = (k >= start) && (k < start + len);
                e.be_n[k]     = !in_span;
                e.dq[8*k +: 8] = wdata[8*(k % len) +: 8];
                if (in_span) ref_mem[idx][8*k +: 8] = wdata[8*(k - start) +: 8];
            end
        end else begin
            e.is_write  = 1'b0;
            e.stall     = READ_WAIT + 1;
            e.we_cycles = 0;
            e.oe_cycles = READ_WAIT;
            e.be_n      = 4'h0;
            e.dq        = 32'h0;
            mask = (len == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * len)) - 32'h1);
            v    = (ref_mem[idx] >> (8 * start)) & mask;
            if (ctrl[2] && len < 4 && v[8*len-1]) v = v | ~mask;
            e.rdata = v;
        end
        return e;
    endfunction

    // Issue one request (called just after a rising edge) and hold it until DONE.
    task automatic do_req(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
        bit done = 1'b0;
        sb_q.push_back(predict(ctrl, addr, wdata));
        mem_addr        = addr;
        mem_wdata       = wdata;
        mem_ctrl_signal = ctrl;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_50M);
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("req_timeout", {31'h0, mem_stall}, 32'h0);
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        mem_ctrl_signal = 5'b00000;
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // Monitor: measures each access and compares against the scoreboard at DONE.
    initial begin
        int          stall_cnt = 0;
        int          we_cnt    = 0;
        int          oe_cnt    = 0;
        logic [19:0] cap_addr  = '0;
        logic [3:0]  cap_be    = 4'hF;
        logic [31:0] cap_dq    = 32'h0;
        logic        cap_oe    = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk_50M);
            if (!rst_n || !mon_en) begin
                stall_cnt = 0;
                we_cnt    = 0;
                oe_cnt    = 0;
            end else if (mem_ctrl_signal[0] || mem_ctrl_signal[1]) begin
                if (mem_stall) begin
                    stall_cnt++;
                    if (!sram_we_n) we_cnt++;
                    if (!sram_oe_n) oe_cnt++;
                    if (!sram_ce_n) begin
                        cap_addr = sram_addr;
                        cap_be   = sram_be_n;
                        cap_dq   = sram_dq_o;
                        cap_oe   = sram_dq_oe;
                    end
                end else if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    check("we_low_cycles", 32'(we_cnt), 32'(e.we_cycles));
                    check("oe_low_cycles", 32'(oe_cnt), 32'(e.oe_cycles));
                    check("sram_addr", {12'h0, cap_addr}, {12'h0, e.waddr});
                    check("sram_be_n", {28'h0, cap_be}, {28'h0, e.be_n});
                    check("done_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
                          32'h0000_000E);
                    if (e.is_write) begin
                        check("sram_dq_o", cap_dq, e.dq);
                        check("dq_oe_write", {31'h0, cap_oe}, 32'h1);
                    end else begin
                        check("mem_rdata", mem_rdata, e.rdata);
                        check("dq_oe_read", {31'h0, cap_oe}, 32'h0);
                    end
                    stall_cnt = 0;
                    we_cnt    = 0;
                    oe_cnt    = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  c;
        bit          seen_we;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        // Reset values, with a request present to show stall stays low.
        rst_n           = 1'b0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;
        mem_ctrl_signal = R_WORD;
        #35;
        check("rst_stall", {31'h0, mem_stall}, 32'h0);
        check("rst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'h0000_000E);
        check("rst_be_n", {28'h0, sram_be_n}, 32'h0000_000F);
        check("rst_addr", {12'h0, sram_addr}, 32'h0);
        check("rst_dq_o", sram_dq_o, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        mem_ctrl_signal = 5'b00000;
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(posedge clk_50M);
        #1;

        // Reset asserted during the we_n pulse aborts the write at once.
        mem_addr        = 32'h0000_00FC;
        mem_wdata       = 32'h5555_AAAA;
        mem_ctrl_signal = W_WORD;
        seen_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_50M);
            if (!sram_we_n) begin
                seen_we = 1'b1;
                break;
            end
        end
        check("rst_we_seen", {31'h0, seen_we}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_we_n", {31'h0, sram_we_n}, 32'h1);
        check("abort_ce_n", {31'h0, sram_ce_n}, 32'h1);
        check("abort_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("abort_stall", {31'h0, mem_stall}, 32'h0);
        mem_ctrl_signal = 5'b00000;
        @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);
        check("post_rst_stall", {31'h0, mem_stall}, 32'h0);
        check("post_rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
        @(posedge clk_50M);
        #1;
        mon_en = 1'b1;

        // Word write then read back.
        do_req(W_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
        idle(1);
        do_req(R_WORD, 32'h0000_0010, 32'h0);
        check("rd_deadbeef", mem_rdata, 32'hDEAD_BEEF);
        idle(1);

        // Lane selection and extension on word 0x80FF7F01.
        do_req(W_WORD, 32'h0000_0020, 32'h80FF_7F01);
        do_req(R_BYTE_S, 32'h0000_0023, 32'h0);
        check("lb_s_lane3", mem_rdata, 32'hFFFF_FF80);
        do_req(R_BYTE_U, 32'h0000_0022, 32'h0);
        check("lb_u_lane2", mem_rdata, 32'h0000_00FF);
        do_req(R_HALF_S, 32'h0000_0020, 32'h0);
        check("lh_s_low", mem_rdata, 32'h0000_7F01);
        do_req(R_HALF_S, 32'h0000_0022, 32'h0);
        check("lh_s_high", mem_rdata, 32'hFFFF_80FF);

        // Byte store into lane 1, then read the whole word.
        do_req(W_BYTE, 32'h0000_0021, 32'h0000_00AB);
        do_req(R_WORD, 32'h0000_0020, 32'h0);
        check("sb_merge", mem_rdata, 32'h80FF_AB01);

        // Read immediately followed by a write, then verify both addresses.
        do_req(R_WORD, 32'h0000_0010, 32'h0);
        check("b2b_read", mem_rdata, 32'hDEAD_BEEF);
        do_req(W_WORD, 32'h0000_0014, 32'h1234_5678);
        do_req(R_WORD, 32'h0000_0014, 32'h0);
        check("b2b_write_lands", mem_rdata, 32'h1234_5678);

        // Misaligned word read is forced aligned.
        do_req(R_WORD, 32'h0000_0013, 32'h0);
        check("misaligned_word", mem_rdata, 32'hDEAD_BEEF);

        // Randomized traffic; word index 63 is excluded (touched by the aborted write).
        for (int n = 0; n < 80; n++) begin
            a = {10'($urandom), 14'h0, 6'($urandom_range(0, 62)), 2'($urandom)};
            c = 5'($urandom);
            if (!c[0] && !c[1]) c[0] = 1'b1;
            do_req(c, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
